// File: rtl/clock_set_mp.sv
// clock_set_mp: K-way fully associative cache set with CLOCK (second-chance)
// replacement, NRD registered read ports, a valid/ready write port whose
// full-set misses scan for a victim one way per cycle, an invalidate port,
// eviction reporting and a registered occupancy count.
module clock_set_mp #(
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WIDTH = 32,
    parameter int K          = 4,
    parameter int NRD        = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NRD-1:0]              rd_en,
    input  logic [NRD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NRD-1:0]              rd_valid,
    output logic [NRD-1:0]              rd_hit,
    output logic [NRD*LINE_WIDTH-1:0]   rd_val,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [LINE_WIDTH-1:0]       wr_val,
    output logic                        wr_done,
    output logic                        wr_hit,
    input  logic                        inv_en,
    input  logic [ADDR_WIDTH-1:0]       inv_addr,
    output logic                        evict_valid,
    output logic [ADDR_WIDTH-1:0]       evict_addr,
    output logic [LINE_WIDTH-1:0]       evict_val,
    output logic [$clog2(K+1)-1:0]      occupancy
);
    localparam int HW = (K > 1) ? $clog2(K) : 1;
    localparam int OW = $clog2(K + 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [ADDR_WIDTH-1:0] line_addr [K];
    logic [LINE_WIDTH-1:0] line_val  [K];
    logic [K-1:0]          line_valid;
    logic [K-1:0]          line_ref;
    logic [HW-1:0]         hand;
    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [LINE_WIDTH-1:0] pend_val;

    logic [ADDR_WIDTH-1:0] addr_nx [K];
    logic [LINE_WIDTH-1:0] val_nx  [K];
    logic [K-1:0]          valid_nx;
    logic [K-1:0]          ref_nx;
    logic [HW-1:0]         hand_nx;
    logic [0:0]            state_nx;
    logic [ADDR_WIDTH-1:0] pend_addr_nx;
    logic [LINE_WIDTH-1:0] pend_val_nx;
    logic [NRD-1:0]        rd_hit_nx;
    logic [NRD*LINE_WIDTH-1:0] rd_val_nx;
    logic                  done_nx;
    logic                  whit_nx;
    logic                  ev_nx;
    logic [ADDR_WIDTH-1:0] ev_addr_nx;
    logic [LINE_WIDTH-1:0] ev_val_nx;
    logic [OW-1:0]         occ_nx;

    logic                  wr_match;
    logic [HW-1:0]         wr_idx;
    logic                  free_found;
    logic [HW-1:0]         free_idx;
    logic                  wr_accept;
    logic                  inv_apply;

    assign wr_ready  = (state == S_IDLE) && !reset;
    assign wr_accept = wr_valid && wr_ready;
    // A same-address write overrides the invalidate; otherwise both apply.
    assign inv_apply = inv_en && wr_ready && !(wr_valid && (wr_addr == inv_addr));

    // Write lookup on pre-edge contents: resident way and lowest-index free way
    always_comb begin
        wr_match   = 1'b0;
        wr_idx     = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < K; i++) begin
            if (line_valid[i] && (line_addr[i] == wr_addr)) begin
                wr_match = 1'b1;
                wr_idx   = HW'(i);
            end
        end
        for (int i = K - 1; i >= 0; i--) begin
            if (!line_valid[i]) begin
                free_found = 1'b1;
                free_idx   = HW'(i);
            end
        end
    end

    // Next-state of the set: scan clear, read refs, invalidate, write, then replacement (which wins)
    always_comb begin
        addr_nx      = line_addr;
        val_nx       = line_val;
        valid_nx     = line_valid;
        ref_nx       = line_ref;
        hand_nx      = hand;
        state_nx     = state;
        pend_addr_nx = pend_addr;
        pend_val_nx  = pend_val;
        rd_hit_nx    = '0;
        rd_val_nx    = '0;
        done_nx      = 1'b0;
        whit_nx      = 1'b0;
        ev_nx        = 1'b0;
        ev_addr_nx   = '0;
        ev_val_nx    = '0;
        occ_nx       = '0;

        if (state == S_SCAN) begin
            if (line_ref[hand]) ref_nx[hand] = 1'b0;
            hand_nx = (hand == HW'(K - 1)) ? '0 : hand + 1'b1;
        end

        for (int c = 0; c < NRD; c++) begin
            for (int i = 0; i < K; i++) begin
                if (rd_en[c] && line_valid[i] &&
                    (line_addr[i] == rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    rd_hit_nx[c] = 1'b1;
                    rd_val_nx[c*LINE_WIDTH +: LINE_WIDTH] = line_val[i];
                    ref_nx[i] = 1'b1;
                end
            end
        end

        if (inv_apply) begin
            for (int i = 0; i < K; i++) begin
                if (line_valid[i] && (line_addr[i] == inv_addr)) begin
                    valid_nx[i] = 1'b0;
                    ref_nx[i]   = 1'b0;
                end
            end
        end

        if (wr_accept) begin
            if (wr_match) begin
                val_nx[wr_idx] = wr_val;
                ref_nx[wr_idx] = 1'b1;
                done_nx        = 1'b1;
                whit_nx        = 1'b1;
            end else if (free_found) begin
                addr_nx[free_idx]  = wr_addr;
                val_nx[free_idx]   = wr_val;
                valid_nx[free_idx] = 1'b1;
                ref_nx[free_idx]   = 1'b1;
                done_nx            = 1'b1;
            end else begin
                pend_addr_nx = wr_addr;
                pend_val_nx  = wr_val;
                state_nx     = S_SCAN;
            end
        end

        if ((state == S_SCAN) && !line_ref[hand]) begin
            if (line_valid[hand]) begin
                ev_nx      = 1'b1;
                ev_addr_nx = line_addr[hand];
                ev_val_nx  = line_val[hand];
            end
            addr_nx[hand]  = pend_addr;
            val_nx[hand]   = pend_val;
            valid_nx[hand] = 1'b1;
            ref_nx[hand]   = 1'b1;
            done_nx        = 1'b1;
            state_nx       = S_IDLE;
        end

        for (int i = 0; i < K; i++) occ_nx = occ_nx + OW'(valid_nx[i]);
    end

    // Register set contents, control state and all outputs; reset clears everything
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < K; i++) begin
                line_addr[i] <= '0;
                line_val[i]  <= '0;
            end
            line_valid  <= '0;
            line_ref    <= '0;
            hand        <= '0;
            state       <= S_IDLE;
            pend_addr   <= '0;
            pend_val    <= '0;
            rd_valid    <= '0;
            rd_hit      <= '0;
            rd_val      <= '0;
            wr_done     <= 1'b0;
            wr_hit      <= 1'b0;
            evict_valid <= 1'b0;
            evict_addr  <= '0;
            evict_val   <= '0;
            occupancy   <= '0;
        end else begin
            line_addr   <= addr_nx;
            line_val    <= val_nx;
            line_valid  <= valid_nx;
            line_ref    <= ref_nx;
            hand        <= hand_nx;
            state       <= state_nx;
            pend_addr   <= pend_addr_nx;
            pend_val    <= pend_val_nx;
            rd_valid    <= rd_en;
            rd_hit      <= rd_hit_nx;
            rd_val      <= rd_val_nx;
            wr_done     <= done_nx;
            wr_hit      <= whit_nx;
            evict_valid <= ev_nx;
            evict_addr  <= ev_addr_nx;
            evict_val   <= ev_val_nx;
            occupancy   <= occ_nx;
        end
    end

endmodule

// File: doc/clock_set_mp.md
Name: clock_set_mp

Overview:
- K-way fully associative cache set with CLOCK (second-chance) replacement.
- NRD independent registered read ports, one valid/ready write port with multi-cycle miss eviction, an invalidate port, an eviction output and an occupancy count.
- Successor to the 2-channel set: parametrised read-channel count, synchronous reset, explicit handshake, read-driven reference bits, eviction reporting.

Parameters:
ADDR_WIDTH, 8, tag/address width in bits
LINE_WIDTH, 32, data width per line in bits
K, 4, number of ways (K >= 2, need not be a power of two)
NRD, 2, number of read channels (>= 1)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
rd_en  input  NRD  per-channel read request
rd_addr  input  NRD*ADDR_WIDTH  channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
rd_valid  output  NRD  registered copy of rd_en
rd_hit  output  NRD  read hit, qualified by rd_valid
rd_val  output  NRD*LINE_WIDTH  read data, channel c at [c*LINE_WIDTH +: LINE_WIDTH]
wr_valid  input  1  write request
wr_ready  output  1  write/invalidate can be accepted
wr_addr  input  ADDR_WIDTH  write address
wr_val  input  LINE_WIDTH  write data
wr_done  output  1  one-cycle pulse: accepted write has completed
wr_hit  output  1  valid with wr_done; 1 = address was already resident
inv_en  input  1  invalidate request, honoured only when wr_ready=1
inv_addr  input  ADDR_WIDTH  address to invalidate
evict_valid  output  1  one-cycle pulse: a valid line was replaced
evict_addr  output  ADDR_WIDTH  address of the replaced line
evict_val  output  LINE_WIDTH  data of the replaced line
occupancy  output  $clog2(K+1)  number of valid lines

Behaviour:
- Reset (sync, while reset=1):
  - All lines valid=0, ref=0, addr/val=0.
  - Clock hand=0, state=IDLE.
  - All outputs 0, including wr_ready; wr_ready=1 the first cycle after reset drops.
  - Reset mid-SCAN aborts the write: no wr_done, no evict_valid.
- Line state: addr, val, valid, ref. Addresses are never duplicated, since writes always check for a hit first.
- Reads, latency 1, all channels independent and concurrent:
  - Next cycle: rd_valid[c]=rd_en[c]; rd_hit[c]=rd_en[c] && (some valid line matches).
  - rd_val[c] = matching line's val on hit, else 0.
  - Reads sample pre-edge contents; a same-cycle write/fill/evict is not visible until the following cycle.
  - A read hit sets that line's ref=1. Reads are legal in any state, including SCAN.
- Write accept: wr_valid && wr_ready. wr_ready=1 only in IDLE and not in reset. Lookup uses pre-edge state.
  - Hit: update val, ref=1. Next cycle wr_done=1, wr_hit=1. Stay IDLE.
  - Miss with a free line: fill the lowest-index invalid line (addr, val, valid=1, ref=1). Next cycle wr_done=1, wr_hit=0, no eviction. Hand unchanged.
  - Miss with set full: latch addr/val, go to SCAN; wr_ready=0 from the next cycle.
- SCAN, one line per cycle at the hand:
  - ref=1: clear ref, hand advances.
  - ref=0: replace the line (latched addr/val, ref=1, valid=1) and hand advances.
    - Next cycle: evict_valid=1 with old addr/val, wr_done=1, wr_hit=0.
    - Return to IDLE (wr_ready=1 in the same cycle as wr_done).
  - Hand wraps K-1 -> 0. Worst-case SCAN length is K+1 cycles; a read hit during SCAN can extend this by re-setting ref.
  - If a read hit and an eviction target the same line in one cycle, eviction wins (new line ref=1).
- Invalidate, only when wr_ready=1:
  - Clears valid and ref of the matching valid line; no output pulse.
  - Ignored when wr_ready=0 or no match.
- Write and invalidate in the same cycle:
  - Same address: the write wins and the line stays valid with the new data.
  - Different addresses: both apply. A line freed by that invalidate is not used by that write's fill decision.
- occupancy: registered count of valid lines, updated the cycle after each fill/invalidate; unchanged by replacement.

Test Plan:
1. K=4, NRD=2, after reset write A=0x10/0x11/0x12/0x13 with vals 0xA0..0xA3 -> each wr_done next cycle with wr_hit=0, lines 0..3 filled, occupancy=4, no evict_valid.
2. Read 0x12 on ch0 and 0x55 on ch1 in the same cycle -> next cycle rd_valid=11; ch0 rd_hit=1, rd_val=0xA2; ch1 rd_hit=0, rd_val=0.
3. Full set, all ref=1, hand=0, write 0x20/0xB0 -> wr_ready low; 4 clearing cycles then replace line 0 -> evict_valid with addr 0x10, val 0xA0; wr_done, wr_hit=0.
4. Write 0x11/0xCC (resident) -> wr_done next cycle, wr_hit=1; a read of 0x11 in the accept cycle returns 0xA1, a read one cycle later returns 0xCC.
5. Invalidate 0x13, then write 0x30 -> fills line 3 with no eviction, occupancy 4 -> 3 -> 4; an inv_en asserted during SCAN is ignored.
6. Assert reset during SCAN -> no wr_done or evict; next cycle wr_ready=1, occupancy=0, and reads of prior addresses miss.
